// File: rtl/adv7513_pkg.sv
// -----------------------------------------------------------------------------
// adv7513_pkg
// Shared definitions for the ADV7513 HDMI transmitter configuration sequencer:
//   - state_t       : sequencer FSM states
//   - CFG_ENTRY_W   : width of one configuration entry {reg_addr, data}
//   - MAX_RETRIES   : consecutive readback mismatches tolerated per entry
//   - REG_*         : named ADV7513 register addresses
//   - cfg_entry()   : the power-up register write table, index -> {reg, data}
// -----------------------------------------------------------------------------
package adv7513_pkg;

    localparam int CFG_ENTRY_W   = 16;
    localparam int MAX_RETRIES   = 3;
    localparam int CFG_TABLE_LEN = 32;

    // Named ADV7513 registers
    localparam logic [7:0] REG_POWER     = 8'h41;  // power-down control
    localparam logic [7:0] REG_FIXED_98  = 8'h98;  // fixed setting
    localparam logic [7:0] REG_FIXED_9A  = 8'h9A;  // fixed setting
    localparam logic [7:0] REG_FIXED_9C  = 8'h9C;  // fixed setting
    localparam logic [7:0] REG_FIXED_E0  = 8'hE0;  // fixed setting
    localparam logic [7:0] REG_IN_FMT    = 8'h15;  // input video format
    localparam logic [7:0] REG_OUT_FMT   = 8'h16;  // output video format
    localparam logic [7:0] REG_HDMI_MODE = 8'hAF;  // HDMI/DVI mode select

    typedef enum logic [2:0] {
        PWR_WAIT,
        ISSUE,
        WAIT_DONE,
        RD_ISSUE,
        RD_WAIT,
        NEXT,
        DONE,
        ERROR
    } state_t;

    // Register write table. The first four entries form the minimum bring-up
    // (power up, mandatory fixed value, input/output format) so that a build
    // with a short NUM_WRITES still yields a working transmitter.
    function automatic logic [CFG_ENTRY_W-1:0] cfg_entry(input logic [7:0] idx);
        logic [CFG_ENTRY_W-1:0] entry;
        case (idx)
            8'd0:    entry = {REG_POWER,     8'h10};  // leave power-down
            8'd1:    entry = {REG_FIXED_98,  8'h03};
            8'd2:    entry = {REG_IN_FMT,    8'h00};  // 24-bit RGB 4:4:4
            8'd3:    entry = {REG_OUT_FMT,   8'h30};  // 4:4:4, 8 bit
            8'd4:    entry = {REG_FIXED_9A,  8'hE0};
            8'd5:    entry = {REG_FIXED_9C,  8'h30};
            8'd6:    entry = {8'h9D,         8'h61};  // input clock divide
            8'd7:    entry = {8'hA2,         8'hA4};
            8'd8:    entry = {8'hA3,         8'hA4};
            8'd9:    entry = {REG_FIXED_E0,  8'hD0};
            8'd10:   entry = {8'hF9,         8'h00};
            8'd11:   entry = {REG_HDMI_MODE, 8'h06};  // HDMI mode
            8'd12:   entry = {8'h17,         8'h02};  // 16:9 aspect
            8'd13:   entry = {8'h18,         8'h46};  // colour space converter off
            8'd14:   entry = {8'h40,         8'h80};  // general control packet on
            8'd15:   entry = {8'h48,         8'h08};  // input justification
            8'd16:   entry = {8'h49,         8'hA8};
            8'd17:   entry = {8'h4C,         8'h00};
            8'd18:   entry = {8'h55,         8'h00};  // AVI infoframe: RGB
            8'd19:   entry = {8'h56,         8'h08};
            8'd20:   entry = {8'h96,         8'h20};  // clear HPD interrupt
            8'd21:   entry = {8'hD6,         8'hC0};  // HPD forced high
            8'd22:   entry = {8'hBA,         8'h60};  // clock delay
            8'd23:   entry = {8'hD0,         8'h3C};
            8'd24:   entry = {8'h01,         8'h00};  // audio N = 6144
            8'd25:   entry = {8'h02,         8'h18};
            8'd26:   entry = {8'h03,         8'h00};
            8'd27:   entry = {8'h0A,         8'h01};  // audio select
            8'd28:   entry = {8'h0C,         8'h3C};  // I2S format
            8'd29:   entry = {8'h73,         8'h01};  // audio channel count
            8'd30:   entry = {8'h3B,         8'h80};
            8'd31:   entry = {8'h94,         8'hC0};  // HPD interrupt enable
            default: entry = '0;
        endcase
        return entry;
    endfunction

endpackage

// File: rtl/adv7513_cfg_rom.sv
// -----------------------------------------------------------------------------
// adv7513_cfg_rom
// Combinational lookup of the configuration table held in adv7513_pkg.
// Ports:
//   index    in  8  table index
//   reg_addr out 8  register address of entry [index]
//   data     out 8  write data of entry [index]
// Entries beyond the table return 8'h00/8'h00.
// -----------------------------------------------------------------------------
module adv7513_cfg_rom
    import adv7513_pkg::*;
(
    input  logic [7:0] index,
    output logic [7:0] reg_addr,
    output logic [7:0] data
);

    // Full 256-deep image so the 8-bit index selects without truncation.
    logic [CFG_ENTRY_W-1:0] rom [256];

    genvar gi;
    generate
        for (gi = 0; gi < 256; gi++) begin : g_rom
            assign rom[gi] = cfg_entry(8'(gi));
        end
    endgenerate

    assign {reg_addr, data} = rom[index];

endmodule

// File: rtl/adv7513_init_ctrl.sv
// -----------------------------------------------------------------------------
// adv7513_init_ctrl
// Power-up / hot-plug configuration sequencer for the ADV7513. Waits out the
// transmitter power-on delay, then writes the table from adv7513_cfg_rom via
// the shared I2C master. Re-runs the table on every HPD rising edge.
//
// Optional feature: define ADV7513_VERIFY_EN to read back each register after
// writing it and retry (up to MAX_RETRIES consecutive mismatches) on mismatch.
//
// Parameters: CHIP_ADDR, STARTUP_DELAY, TIMEOUT, NUM_WRITES (1..255)
// Ports:
//   clock          in   system clock, rising edge
//   reset          in   synchronous, active-low
//   hpd            in   hot-plug detect (already synchronous)
//   i2c_start      out  one-cycle transaction launch
//   i2c_write_en   out  1 = write, 0 = read
//   i2c_chip_addr  out  7-bit device address (CHIP_ADDR)
//   i2c_reg_addr   out  register address of current entry
//   i2c_wdata      out  write data of current entry
//   i2c_rdata      in   read data, valid with i2c_done
//   i2c_busy       in   master mid-transaction
//   i2c_done       in   one-cycle transaction-complete pulse
//   init_done      out  table completed without error
//   init_error     out  aborted by timeout / verify failure
//   err_index      out  index of the failing entry
// -----------------------------------------------------------------------------
module adv7513_init_ctrl
    import adv7513_pkg::*;
#(
    parameter logic [6:0]  CHIP_ADDR     = 7'h39,
    parameter logic [31:0] STARTUP_DELAY = 32'd10_000_000,
    parameter logic [31:0] TIMEOUT       = 32'd1_000_000,
    parameter logic [7:0]  NUM_WRITES    = 8'd32
)(
    input  logic       clock,
    input  logic       reset,
    input  logic       hpd,
    output logic       i2c_start,
    output logic       i2c_write_en,
    output logic [6:0] i2c_chip_addr,
    output logic [7:0] i2c_reg_addr,
    output logic [7:0] i2c_wdata,
    input  logic [7:0] i2c_rdata,
    input  logic       i2c_busy,
    input  logic       i2c_done,
    output logic       init_done,
    output logic       init_error,
    output logic [7:0] err_index
);

    state_t      state_reg, state_next;
    logic [31:0] delay_cnt_reg, delay_cnt_next;
    logic [31:0] tmo_cnt_reg, tmo_cnt_next;
    logic [7:0]  index_reg, index_next;
    logic        hpd_prev_reg;
    logic        hpd_pending_reg, hpd_pending_next;
    logic        start_reg, start_next;
    logic        write_en_reg, write_en_next;
    logic [7:0]  reg_addr_reg, reg_addr_next;
    logic [7:0]  wdata_reg, wdata_next;
    logic        done_reg, done_next;
    logic        error_reg, error_next;
    logic [7:0]  err_index_reg, err_index_next;
`ifdef ADV7513_VERIFY_EN
    logic [1:0]  retry_reg, retry_next;
`else
    logic        unused_rdata;
    assign unused_rdata = ^i2c_rdata;
`endif

    logic [7:0]  rom_reg_addr;
    logic [7:0]  rom_data;
    logic        hpd_rise;
    logic        in_sequence;

    adv7513_cfg_rom u_cfg_rom (
        .index    (index_reg),
        .reg_addr (rom_reg_addr),
        .data     (rom_data)
    );

    assign hpd_rise    = hpd & ~hpd_prev_reg;
    assign in_sequence = state_reg inside {ISSUE, WAIT_DONE, RD_ISSUE, RD_WAIT, NEXT};

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg       <= PWR_WAIT;
            delay_cnt_reg   <= '0;
            tmo_cnt_reg     <= '0;
            index_reg       <= '0;
            hpd_prev_reg    <= 1'b0;
            hpd_pending_reg <= 1'b0;
            start_reg       <= 1'b0;
            write_en_reg    <= 1'b0;
            reg_addr_reg    <= '0;
            wdata_reg       <= '0;
            done_reg        <= 1'b0;
            error_reg       <= 1'b0;
            err_index_reg   <= '0;
`ifdef ADV7513_VERIFY_EN
            retry_reg       <= '0;
`endif
        end else begin
            state_reg       <= state_next;
            delay_cnt_reg   <= delay_cnt_next;
            tmo_cnt_reg     <= tmo_cnt_next;
            index_reg       <= index_next;
            hpd_prev_reg    <= hpd;
            hpd_pending_reg <= hpd_pending_next;
            start_reg       <= start_next;
            write_en_reg    <= write_en_next;
            reg_addr_reg    <= reg_addr_next;
            wdata_reg       <= wdata_next;
            done_reg        <= done_next;
            error_reg       <= error_next;
            err_index_reg   <= err_index_next;
`ifdef ADV7513_VERIFY_EN
            retry_reg       <= retry_next;
`endif
        end
    end

    always_comb begin
        state_next       = state_reg;
        delay_cnt_next   = delay_cnt_reg;
        tmo_cnt_next     = tmo_cnt_reg;
        index_next       = index_reg;
        hpd_pending_next = hpd_pending_reg;
        start_next       = 1'b0;
`ifdef ADV7513_VERIFY_EN
        write_en_next    = write_en_reg;
        retry_next       = retry_reg;
`else
        write_en_next    = 1'b1;
`endif
        reg_addr_next    = reg_addr_reg;
        wdata_next       = wdata_reg;
        done_next        = done_reg;
        error_next       = error_reg;
        err_index_next   = err_index_reg;

        // A hot-plug during a transaction is remembered and honoured at NEXT,
        // so the transaction in flight always completes.
        if (hpd_rise && in_sequence) begin
            hpd_pending_next = 1'b1;
        end

        case (state_reg)
            PWR_WAIT: begin
                if (delay_cnt_reg >= STARTUP_DELAY - 32'd1) begin
                    state_next = ISSUE;
                    index_next = '0;
                end else begin
                    delay_cnt_next = delay_cnt_reg + 32'd1;
                end
            end

            ISSUE: begin
                if (!i2c_busy) begin
                    start_next    = 1'b1;
                    write_en_next = 1'b1;
                    reg_addr_next = rom_reg_addr;
                    wdata_next    = rom_data;
                    tmo_cnt_next  = '0;
                    state_next    = WAIT_DONE;
                end
            end

            WAIT_DONE: begin
                if (i2c_done) begin
`ifdef ADV7513_VERIFY_EN
                    state_next = RD_ISSUE;
`else
                    state_next = NEXT;
`endif
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 32'd1;
                    if (tmo_cnt_next >= TIMEOUT) begin
                        state_next     = ERROR;
                        error_next     = 1'b1;
                        err_index_next = index_reg;
                    end
                end
            end

`ifdef ADV7513_VERIFY_EN
            RD_ISSUE: begin
                // Address/data registers still hold the entry just written.
                if (!i2c_busy) begin
                    start_next    = 1'b1;
                    write_en_next = 1'b0;
                    tmo_cnt_next  = '0;
                    state_next    = RD_WAIT;
                end
            end

            RD_WAIT: begin
                if (i2c_done) begin
                    if (i2c_rdata == wdata_reg) begin
                        state_next = NEXT;
                    end else if (retry_reg == 2'(MAX_RETRIES - 1)) begin
                        state_next     = ERROR;
                        error_next     = 1'b1;
                        err_index_next = index_reg;
                    end else begin
                        retry_next = retry_reg + 2'd1;
                        state_next = ISSUE;
                    end
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 32'd1;
                    if (tmo_cnt_next >= TIMEOUT) begin
                        state_next     = ERROR;
                        error_next     = 1'b1;
                        err_index_next = index_reg;
                    end
                end
            end
`endif

            NEXT: begin
`ifdef ADV7513_VERIFY_EN
                retry_next = '0;
`endif
                if (hpd_pending_reg || hpd_rise) begin
                    hpd_pending_next = 1'b0;
                    index_next       = '0;
                    state_next       = ISSUE;
                end else if (index_reg == NUM_WRITES - 8'd1) begin
                    done_next  = 1'b1;
                    state_next = DONE;
                end else begin
                    index_next = index_reg + 8'd1;
                    state_next = ISSUE;
                end
            end

            DONE: begin
                if (hpd_rise) begin
                    done_next        = 1'b0;
                    index_next       = '0;
                    hpd_pending_next = 1'b0;
`ifdef ADV7513_VERIFY_EN
                    retry_next       = '0;
`endif
                    state_next       = ISSUE;
                end
            end

            ERROR: begin
                // A hot-plug edge that arrived before the abort must not cause a
                // second restart later, so the pending flag is dropped here.
                if (hpd_rise) begin
                    error_next       = 1'b0;
                    err_index_next   = '0;
                    index_next       = '0;
                    hpd_pending_next = 1'b0;
`ifdef ADV7513_VERIFY_EN
                    retry_next       = '0;
`endif
                    state_next       = ISSUE;
                end
            end

            default: begin
                state_next = PWR_WAIT;
            end
        endcase
    end

    assign i2c_start     = start_reg;
    assign i2c_write_en  = write_en_reg;
    assign i2c_chip_addr = CHIP_ADDR;
    assign i2c_reg_addr  = reg_addr_reg;
    assign i2c_wdata     = wdata_reg;
    assign init_done     = done_reg;
    assign init_error    = error_reg;
    assign err_index     = err_index_reg;

endmodule

// File: tb/tb_adv7513_init_ctrl.sv
// -----------------------------------------------------------------------------
// tb_adv7513_init_ctrl
// Directed bench for adv7513_init_ctrl with a behavioural I2C master mock.
// Uses a 4-entry table (NUM_WRITES = 4), STARTUP_DELAY = 16, TIMEOUT = 100.
// -----------------------------------------------------------------------------
module tb_adv7513_init_ctrl;

    localparam int ACK_DELAY = 50;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       hpd = 1'b0;
    logic       i2c_start;
    logic       i2c_write_en;
    logic [6:0] i2c_chip_addr;
    logic [7:0] i2c_reg_addr;
    logic [7:0] i2c_wdata;
    logic [7:0] i2c_rdata = 8'h00;
    logic       i2c_busy;
    logic       i2c_done = 1'b0;
    logic       init_done;
    logic       init_error;
    logic [7:0] err_index;

    // Bench controls (driven from the main initial block)
    logic       busy_force = 1'b0;
    logic       hang_en = 1'b0;
    logic [7:0] hang_addr = 8'h00;
    int         bad_limit = 0;

    // Mock state
    logic       mock_busy = 1'b0;
    logic       cur_hang = 1'b0;
    logic       cur_we = 1'b0;
    logic [7:0] cur_reg = 8'h00;
    int         mock_cnt = 0;
    int         rd98_cnt = 0;
    int         bad_start = 0;
    int         cyc = 0;
    int         txn_count = 0;
    logic       txn_we  [128];
    logic [7:0] txn_reg [128];
    logic [7:0] txn_dat [128];
    int         txn_cyc [128];
    logic [7:0] mem [256];

    int n_checks = 0;
    int n_fail = 0;
    int rel_cyc = 0;
    int base = 0;
    int last = 0;

    assign i2c_busy = mock_busy | busy_force;

    adv7513_init_ctrl #(
        .CHIP_ADDR     (7'h39),
        .STARTUP_DELAY (32'd16),
        .TIMEOUT       (32'd100),
        .NUM_WRITES    (8'd4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .hpd           (hpd),
        .i2c_start     (i2c_start),
        .i2c_write_en  (i2c_write_en),
        .i2c_chip_addr (i2c_chip_addr),
        .i2c_reg_addr  (i2c_reg_addr),
        .i2c_wdata     (i2c_wdata),
        .i2c_rdata     (i2c_rdata),
        .i2c_busy      (i2c_busy),
        .i2c_done      (i2c_done),
        .init_done     (init_done),
        .init_error    (init_error),
        .err_index     (err_index)
    );

    always #5 clock = ~clock;

    // I2C master mock: logs each launch, acks after ACK_DELAY cycles unless the
    // register matches hang_addr, returns written data on reads except for the
    // first bad_limit reads of register 8'h98.
    always @(posedge clock) begin
        cyc      <= cyc + 1;
        i2c_done <= 1'b0;
        if (!reset) begin
            mock_busy <= 1'b0;
            cur_hang  <= 1'b0;
            mock_cnt  <= 0;
            rd98_cnt  <= 0;
        end else if (i2c_start) begin
            if (i2c_busy) bad_start <= bad_start + 1;
            if (txn_count < 128) begin
                txn_we[txn_count]  <= i2c_write_en;
                txn_reg[txn_count] <= i2c_reg_addr;
                txn_dat[txn_count] <= i2c_wdata;
                txn_cyc[txn_count] <= cyc;
            end
            txn_count <= txn_count + 1;
            $display("txn %0d: %s reg=%02h data=%02h cycle=%0d", txn_count,
                     i2c_write_en ? "WR" : "RD", i2c_reg_addr, i2c_wdata, cyc);
            if (i2c_write_en) mem[i2c_reg_addr] <= i2c_wdata;
            mock_busy <= 1'b1;
            cur_reg   <= i2c_reg_addr;
            cur_we    <= i2c_write_en;
            mock_cnt  <= ACK_DELAY;
            cur_hang  <= hang_en && (i2c_reg_addr == hang_addr);
        end else if (mock_busy) begin
            if (cur_hang) begin
                if (!hang_en) begin
                    mock_busy <= 1'b0;
                    cur_hang  <= 1'b0;
                end
            end else if (mock_cnt == 1) begin
                i2c_done  <= 1'b1;
                mock_busy <= 1'b0;
                if (!cur_we) begin
                    if (cur_reg == 8'h98 && rd98_cnt < bad_limit) i2c_rdata <= 8'h00;
                    else i2c_rdata <= mem[cur_reg];
                    if (cur_reg == 8'h98) rd98_cnt <= rd98_cnt + 1;
                end
            end else begin
                mock_cnt <= mock_cnt - 1;
            end
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic [7:0] exp_data(input logic [7:0] r);
        case (r)
            8'h41:   return 8'h10;
            8'h98:   return 8'h03;
            8'h15:   return 8'h00;
            8'h16:   return 8'h30;
            default: return 8'hEE;
        endcase
    endfunction

    task automatic check_writes(input int from, input string tag,
                                input logic [7:0] exp_regs [8], input int n_exp);
        int n = 0;
        for (int i = from; i < txn_count; i++) begin
            if (txn_we[i]) begin
                if (n < n_exp) begin
                    check($sformatf("%s_reg%0d", tag, n), int'(txn_reg[i]), int'(exp_regs[n]));
                    check($sformatf("%s_dat%0d", tag, n), int'(txn_dat[i]), int'(exp_data(exp_regs[n])));
                end
                n++;
            end
        end
        check({tag, "_nwrites"}, n, n_exp);
    endtask

    task automatic wait_flag(input bit want_err, input int budget, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if ((want_err ? init_error : init_done) === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check({tag, "_wait_expired"}, 0, 1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic release_reset();
        reset   = 1'b1;
        rel_cyc = cyc;
    endtask

    task automatic hpd_pulse(input string tag, input bit check_flags);
        hpd = 1'b1;
        @(negedge clock);
        if (check_flags) begin
            check({tag, "_done_clr"}, int'(init_done), 0);
            check({tag, "_err_clr"}, int'(init_error), 0);
            check({tag, "_idx_clr"}, int'(err_index), 0);
        end
        hpd = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_start", int'(i2c_start), 0);
        check("rst_we", int'(i2c_write_en), 0);
        check("rst_reg", int'(i2c_reg_addr), 0);
        check("rst_wdata", int'(i2c_wdata), 0);
        check("rst_done", int'(init_done), 0);
        check("rst_error", int'(init_error), 0);
        check("rst_err_index", int'(err_index), 0);
        check("chip_addr", int'(i2c_chip_addr), 'h39);

        // Power-up sequence
        base = txn_count;
        release_reset();
`ifndef ADV7513_VERIFY_EN
        repeat (2) @(negedge clock);
        check("we_after_rst", int'(i2c_write_en), 1);
`endif
        wait_flag(1'b0, 2000, "pwrup");
        check("pwrup_first_start", txn_cyc[base] - rel_cyc, 17);
        check_writes(base, "pwrup", '{8'h41, 8'h98, 8'h15, 8'h16, 8'h0, 8'h0, 8'h0, 8'h0}, 4);
        check("pwrup_done", int'(init_done), 1);
        check("pwrup_error", int'(init_error), 0);

        // HPD recovery from DONE
        repeat (5) @(negedge clock);
        base = txn_count;
        hpd_pulse("hpd_done", 1'b1);
        wait_flag(1'b0, 2000, "hpd_done");
        check_writes(base, "hpd_done", '{8'h41, 8'h98, 8'h15, 8'h16, 8'h0, 8'h0, 8'h0, 8'h0}, 4);

        // Timeout on entry 2
        do_reset();
        hang_en   = 1'b1;
        hang_addr = 8'h15;
        base = txn_count;
        release_reset();
        wait_flag(1'b1, 3000, "tmo");
        last = txn_count;
        check("tmo_latency", cyc - txn_cyc[txn_count - 1], 100);
        check("tmo_err_index", int'(err_index), 2);
        check("tmo_done", int'(init_done), 0);
        check_writes(base, "tmo", '{8'h41, 8'h98, 8'h15, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0}, 3);
        repeat (200) @(negedge clock);
        check("tmo_no_more_starts", txn_count, last);
        check("tmo_error_held", int'(init_error), 1);

        // HPD recovery from ERROR
        hang_en = 1'b0;
        repeat (5) @(negedge clock);
        base = txn_count;
        hpd_pulse("hpd_err", 1'b1);
        wait_flag(1'b0, 2000, "hpd_err");
        check_writes(base, "hpd_err", '{8'h41, 8'h98, 8'h15, 8'h16, 8'h0, 8'h0, 8'h0, 8'h0}, 4);

        // HPD during the write of entry 1
        do_reset();
        base = txn_count;
        release_reset();
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 300; i++) begin
                @(negedge clock);
                if (txn_count > base && txn_we[txn_count - 1] && txn_reg[txn_count - 1] == 8'h98) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (!seen) check("hpdmid_wait_expired", 0, 1);
        end
        hpd_pulse("hpdmid", 1'b0);
        wait_flag(1'b0, 3000, "hpdmid");
        check_writes(base, "hpdmid", '{8'h41, 8'h98, 8'h41, 8'h98, 8'h15, 8'h16, 8'h0, 8'h0}, 6);

        // Start gating by i2c_busy
        do_reset();
        busy_force = 1'b1;
        base = txn_count;
        release_reset();
        repeat (37) @(negedge clock);
        check("gate_no_start", txn_count, base);
        busy_force = 1'b0;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clock);
                if (txn_count > base) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (!seen) check("gate_wait_expired", 0, 1);
        end
        check("gate_start_cycle", txn_cyc[base] - rel_cyc, 38);
        repeat (10) @(negedge clock);
        check("gate_one_pulse", txn_count - base, 1);

        // Reset in the middle of a transaction
        do_reset();
        check("midrst_reg", int'(i2c_reg_addr), 0);
        check("midrst_start", int'(i2c_start), 0);

`ifdef ADV7513_VERIFY_EN
        // Readback of 8'h98 always wrong -> abort on entry 1
        bad_limit = 3;
        base = txn_count;
        release_reset();
        wait_flag(1'b1, 5000, "vfy_bad");
        check("vfy_bad_err_index", int'(err_index), 1);
        begin
            int nw = 0;
            int nr = 0;
            for (int i = base; i < txn_count; i++) begin
                if (txn_reg[i] == 8'h98) begin
                    if (txn_we[i]) nw++;
                    else nr++;
                end
            end
            check("vfy_bad_w98", nw, 3);
            check("vfy_bad_r98", nr, 3);
        end

        // One bad readback then a good one -> completes
        do_reset();
        bad_limit = 1;
        base = txn_count;
        release_reset();
        wait_flag(1'b0, 5000, "vfy_retry");
        check("vfy_retry_done", int'(init_done), 1);
        check("vfy_retry_error", int'(init_error), 0);
        check_writes(base, "vfy_retry", '{8'h41, 8'h98, 8'h98, 8'h15, 8'h16, 8'h0, 8'h0, 8'h0}, 5);
`endif

        check("no_start_while_busy", bad_start, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adv7513_init_ctrl.md
# adv7513_init_ctrl

Power-up and hot-plug configuration sequencer for the ADV7513 HDMI transmitter. It waits out the transmitter's power-on delay, then walks a fixed table of register writes through the shared I2C master's command interface. It re-runs the table whenever HDMI hot-plug detect (HPD) is asserted, and reports done/error status to the video top level.

## Interface
- `CHIP_ADDR`, 7'h39 (7-bit form of 8'h72): ADV7513 I2C address.
- `STARTUP_DELAY`, 32'd10_000_000: cycles from reset release to first transaction (200 ms at 50 MHz).
- `TIMEOUT`, 32'd1_000_000: maximum cycles to wait for `i2c_done` on any transaction.
- `NUM_WRITES`, 8'd32: number of table entries. Valid range 1..255.
- `clock`  in  1  system clock. All logic is clocked on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `hpd`  in  1  hot-plug detect, already synchronised to `clock`.
- `i2c_start`  out  1  one-cycle pulse that launches a transaction.
- `i2c_write_en`  out  1  1 = write, 0 = read. Valid while `i2c_start` is high.
- `i2c_chip_addr`  out  7  always `CHIP_ADDR`.
- `i2c_reg_addr`  out  8  register address of the current entry.
- `i2c_wdata`  out  8  write data of the current entry.
- `i2c_rdata`  in  8  read data. Valid in the cycle `i2c_done` is high.
- `i2c_busy`  in  1  master is mid-transaction.
- `i2c_done`  in  1  one-cycle pulse at transaction end.
- `init_done`  out  1  table completed without error.
- `init_error`  out  1  sequence aborted by timeout or verify failure.
- `err_index`  out  8  table index of the failing entry.

## Operation
- FSM states: `PWR_WAIT`, `ISSUE`, `WAIT_DONE`, `RD_ISSUE`, `RD_WAIT`, `NEXT`, `DONE`, `ERROR`.
- **Reset:** state = `PWR_WAIT`; delay counter, index, timeout counter, retry counter and `hpd_pending` all 0. Outputs at reset: `i2c_start`=0, `i2c_write_en`=0, `i2c_reg_addr`=0, `i2c_wdata`=0, `init_done`=0, `init_error`=0, `err_index`=0.
- **PWR_WAIT:** count up to `STARTUP_DELAY`-1, then go to `ISSUE` with index 0. HPD is ignored in this state.
- **ISSUE:** once `i2c_busy`=0, pulse `i2c_start` for one cycle with `i2c_write_en`=1 and {reg, data} = table[index]. Clear the timeout counter and go to `WAIT_DONE`.
- **WAIT_DONE:** on `i2c_done`, go to `RD_ISSUE` if verify is compiled in, otherwise to `NEXT`. If the timeout counter reaches `TIMEOUT`, go to `ERROR`.
- **NEXT:** if `hpd_pending`, clear it and return to `ISSUE` with index 0. Else, if index = `NUM_WRITES`-1, go to `DONE`. Else increment index and go to `ISSUE`.
- **DONE:** `init_done`=1. A rising edge of `hpd` clears `init_done` and goes to `ISSUE` with index 0.
- **ERROR:** `init_error`=1 and `err_index`=index, both held. A rising edge of `hpd` clears both and restarts at index 0. This is the only recovery path other than reset.
- **HPD edges mid-sequence:** an `hpd` rising edge in `ISSUE`..`NEXT` sets `hpd_pending`. The in-flight transaction is never abandoned; the restart happens at `NEXT`.
- **Table addressing:** index is 8 bits and never wraps, because `NUM_WRITES` ≤ 255.
- **Reset mid-transaction:** `reset` low at any time returns the FSM to `PWR_WAIT`. The I2C master is reset by the same `reset`.

## Timing
- Reset release to first `i2c_start`: `STARTUP_DELAY` + 1 cycles, provided `i2c_busy`=0.
- `i2c_done` to the next `i2c_start`: 2 cycles (through `NEXT`, then `ISSUE`).
- `i2c_start` is never asserted while `i2c_busy`=1 or while in `WAIT_DONE`/`RD_WAIT`.
- `init_done` rises 1 cycle after the final `i2c_done`, entering through `NEXT`.
- An `hpd` edge in `DONE` or `ERROR` is acted on in the next cycle.

## Configuration
- Macro `ADV7513_VERIFY_EN`.
- **Defined:** after each write, issue a read of the same register (`RD_ISSUE`: pulse `i2c_start` with `i2c_write_en`=0, then `RD_WAIT`).
  - On `i2c_done`, compare `i2c_rdata` with the written data.
  - Match: go to `NEXT`.
  - Mismatch: increment the retry counter and rewrite the entry via `ISSUE`. After 3 consecutive mismatches on one entry, go to `ERROR`.
  - The retry counter clears in `NEXT`. `TIMEOUT` also applies in `RD_WAIT`.
- **Undefined:** no reads are issued, `RD_*` states and the retry counter are absent, and `i2c_write_en` is constant 1 after reset.

## Structure
- Package `adv7513_pkg` holds:
  - the FSM state enum;
  - `CFG_ENTRY_W` = 16;
  - `MAX_RETRIES` = 3;
  - named register constants: 8'h41 power-down, 8'h98/8'h9A/8'h9C/8'hE0 fixed settings, 8'h15 input format, 8'h16 output format, 8'hAF HDMI mode.
- Sub-module `adv7513_cfg_rom`: combinational index → {reg_addr, data}, with the table taken from `adv7513_pkg`. The bench substitutes a short 4-entry table.

## Test plan
- **Power-up sequence:** `STARTUP_DELAY`=16, 4-entry table {41:10, 98:03, 15:00, 16:30}, master mock acks every write after 50 cycles → first `i2c_start` at cycle 17 after reset release; 4 writes in table order; `init_done`=1, `init_error`=0.
- **Timeout:** master never asserts `i2c_done` on entry 2, `TIMEOUT`=100 → `ERROR` 100 cycles after the third `i2c_start`; `init_error`=1, `err_index`=2, no further `i2c_start` pulses.
- **HPD mid-sequence:** `hpd` pulses during the write of entry 1 → entry 1 completes, then the next `i2c_start` carries reg 8'h41; 6 writes total before `init_done`.
- **HPD recovery:** `hpd` edge while in `DONE`, and separately while in `ERROR` → flags clear within 1 cycle and all 4 writes repeat.
- **Start gating:** `i2c_busy` held high for 20 cycles at `ISSUE` → no `i2c_start` until `i2c_busy` falls, then exactly one pulse.
- **Verify (`ADV7513_VERIFY_EN`):** readback of reg 8'h98 returns 8'h00 three times → 3 writes and 3 reads of 8'h98, then `init_error`=1, `err_index`=1. Readback returning 8'h03 on the second try → sequence continues to `init_done`.
